shift_serial_tx: RTL and testbench

//  Downstream stage for the shift left/right load register: takes its 8-bit parallel word and

---
 rtl/shift_serial_pkg.sv | 14 +
 rtl/bit_period_counter.sv | 29 ++
 rtl/shift_serial_tx.sv | 113 +++++++++++
 tb/tb_shift_serial_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_serial_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and line levels.
package shift_serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, tick marks the last cycle.
module bit_period_counter #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   assign tick = run && (r_cnt == LAST_CNT);

   // Period counter: held at zero when idle, wraps to zero on each bit boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!run || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/shift_serial_tx.sv
// Serialiser: one start bit, WIDTH data bits (MSB- or LSB-first), one stop bit per frame.
module shift_serial_tx
   import shift_serial_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             msb_first,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_e           r_state;
   state_e           w_state_d;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_sreg_d;
   logic             r_msb;
   logic             w_msb_d;
   logic [BW-1:0]    r_bit;
   logic [BW-1:0]    w_bit_d;
   logic             r_serial;
   logic             w_serial_d;
   logic             w_tick;
   logic             w_run;
   logic             w_accept;

   assign w_run    = (r_state != IDLE);
   assign w_accept = data_valid && (r_state == IDLE);

   bit_period_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_period_counter (
      .clk  (clk),
      .reset(reset),
      .run  (w_run),
      .tick (w_tick)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic: each non-idle state lasts whole bit periods.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_d = START;
         START:   if (w_tick) w_state_d = DATA;
         DATA:    if (w_tick && (r_bit == LAST_BIT)) w_state_d = STOP;
         STOP:    if (w_tick) w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from registered state only.
   always_comb begin
      data_ready = (r_state == IDLE);
      busy       = (r_state != IDLE);
      done       = (r_state == STOP) && w_tick;
   end

   // Datapath next values; the line level is derived from the next state so it stays aligned.
   always_comb begin
      w_sreg_d = r_sreg;
      w_msb_d  = r_msb;
      w_bit_d  = r_bit;
      if (w_accept) begin
         w_sreg_d = data_in;
         w_msb_d  = msb_first;
      end
      if ((r_state == DATA) && w_tick) begin
         w_sreg_d = r_msb ? (r_sreg << 1) : (r_sreg >> 1);
         w_bit_d  = (r_bit == LAST_BIT) ? '0 : r_bit + BW'(1);
      end
      case (w_state_d)
         START:   w_serial_d = START_BIT;
         DATA:    w_serial_d = w_msb_d ? w_sreg_d[WIDTH-1] : w_sreg_d[0];
         default: w_serial_d = STOP_BIT;
      endcase
   end

   // Datapath registers; the line idles high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sreg   <= '0;
         r_msb    <= 1'b0;
         r_bit    <= '0;
         r_serial <= STOP_BIT;
      end else begin
         r_sreg   <= w_sreg_d;
         r_msb    <= w_msb_d;
         r_bit    <= w_bit_d;
         r_serial <= w_serial_d;
      end
   end

   assign serial_out = r_serial;

endmodule

// File: tb/tb_shift_serial_tx.sv
// Self-checking bench: a 4-clock-per-bit instance and a 1-clock-per-bit instance,
// table vectors, hand-written corner cases and random frames against a frame model.
module tb_shift_serial_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       msb_first = 1'b0;
   logic       sel = 1'b0;  // 0: CLKS_PER_BIT=4 instance, 1: CLKS_PER_BIT=1 instance

   logic valid4, ready4, serial4, busy4, done4;
   logic valid1, ready1, serial1, busy1, done1;
   logic ready, serial, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign valid4 = data_valid & ~sel;
   assign valid1 = data_valid & sel;
   assign ready  = sel ? ready1 : ready4;
   assign serial = sel ? serial1 : serial4;
   assign busy   = sel ? busy1 : busy4;
   assign done   = sel ? done1 : done4;

   shift_serial_tx #(
      .WIDTH(8),
      .CLKS_PER_BIT(4)
   ) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .data_valid(valid4),
      .data_ready(ready4),
      .msb_first (msb_first),
      .serial_out(serial4),
      .busy      (busy4),
      .done      (done4)
   );

   shift_serial_tx #(
      .WIDTH(8),
      .CLKS_PER_BIT(1)
   ) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .data_valid(valid1),
      .data_ready(ready1),
      .msb_first (msb_first),
      .serial_out(serial1),
      .busy      (busy1),
      .done      (done1)
   );

   typedef struct {
      logic [7:0] d;
      logic       m;
      logic       s;
      logic [9:0] exp;  // transmit order, first bit leftmost
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Frame as seen on the line, first transmitted bit leftmost.
   function automatic logic [9:0] model_frame(input logic [7:0] d, input logic m);
      logic [7:0] o;
      for (int i = 0; i < 8; i++) o[7-i] = m ? d[7-i] : d[i];
      return {1'b0, o, 1'b1};
   endfunction

   // Present a word and wait (bounded) until it is accepted at a rising edge.
   task automatic accept_word(input logic [7:0] d, input logic m, input logic hold,
                              output int waits);
      data_in    = d;
      msb_first  = m;
      data_valid = 1'b1;
      waits      = 0;
      while (!ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!ready) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!hold) data_valid = 1'b0;
   endtask

   // Observe one full frame after accept plus the following idle cycle.
   task automatic check_frame(input logic [9:0] exp, input int scr_at, input logic [7:0] scr_d,
                              input logic scr_m);
      int cpb;
      int total;
      int bad;
      int busy_n;
      int done_n;
      int done_at;
      logic [9:0] got;
      logic e;
      cpb     = sel ? 1 : 4;
      total   = 10 * cpb;
      bad     = 0;
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      got     = '0;
      for (int k = 1; k <= total + 1; k++) begin
         @(negedge clk);
         if (k <= total) begin
            e = exp[9 - (k - 1) / cpb];
            if (serial !== e) bad++;
            if (ready !== 1'b0) bad++;
            if ((k - 1) % cpb == 0) got = {got[8:0], serial};
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
               done_n++;
               done_at = k;
            end
         end else begin
            check("idle_gap", {28'd0, serial, ready, busy, done}, 32'hC);
         end
         if (scr_at != 0 && k == scr_at) begin
            data_in   = scr_d;
            msb_first = scr_m;
         end
      end
      check("line_bits", {22'd0, got}, {22'd0, exp});
      check("line_cycles_bad", bad, 0);
      check("busy_cycles", busy_n, total);
      check("done_cycle", done_at, total);
      check("done_pulses", done_n, 1);
   endtask

   vec_t vecs[$];
   int   waits;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs.push_back('{d: 8'hA8, m: 1'b1, s: 1'b0, exp: 10'b0101010001});
      vecs.push_back('{d: 8'hFF, m: 1'b0, s: 1'b0, exp: 10'b0111111111});
      vecs.push_back('{d: 8'h00, m: 1'b1, s: 1'b0, exp: 10'b0000000001});
      vecs.push_back('{d: 8'h01, m: 1'b0, s: 1'b0, exp: 10'b0100000001});
      vecs.push_back('{d: 8'h01, m: 1'b1, s: 1'b0, exp: 10'b0000000011});
      vecs.push_back('{d: 8'hA5, m: 1'b0, s: 1'b1, exp: 10'b0101001011});
      vecs.push_back('{d: 8'hA8, m: 1'b1, s: 1'b1, exp: 10'b0101010001});

      // Power-on reset state for both instances.
      #12;
      sel = 1'b0;
      #1 check("reset_state_cpb4", {28'd0, serial, ready, busy, done}, 32'hC);
      sel = 1'b1;
      #1 check("reset_state_cpb1", {28'd0, serial, ready, busy, done}, 32'hC);
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Table vectors.
      foreach (vecs[i]) begin
         if (sel != vecs[i].s) begin
            sel = vecs[i].s;
            @(negedge clk);
         end
         accept_word(vecs[i].d, vecs[i].m, 1'b0, waits);
         check_frame(vecs[i].exp, 0, 8'h00, 1'b0);
      end
      sel = 1'b0;
      @(negedge clk);

      // Input changes while busy are ignored; held word goes out right after done.
      accept_word(8'h0F, 1'b0, 1'b1, waits);
      check_frame(10'b0111100001, 6, 8'h55, 1'b0);
      accept_word(8'h55, 1'b0, 1'b0, waits);
      check("accept_after_done_wait", waits, 0);
      check_frame(10'b0101010101, 0, 8'h00, 1'b0);

      // Reset during data bit 3 abandons the frame immediately.
      accept_word(8'hC3, 1'b1, 1'b0, waits);
      repeat (18) @(negedge clk);
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      #1 reset = 1'b1;
      #1 check("async_reset_mid", {28'd0, serial, ready, busy, done}, 32'hC);
      #11 check("reset_held", {28'd0, serial, ready, busy, done}, 32'hC);
      reset = 1'b0;
      @(negedge clk);
      check("after_reset_idle", {28'd0, serial, ready, busy, done}, 32'hC);
      accept_word(8'h3C, 1'b0, 1'b0, waits);
      check_frame(model_frame(8'h3C, 1'b0), 0, 8'h00, 1'b0);

      // Random frames on both instances, with idle gaps and busy-time input noise.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] d;
         logic       m;
         logic       ns;
         logic       hold;
         int         gap;
         int         scr;
         d    = 8'($urandom);
         m    = 1'($urandom);
         ns   = (i % 4 == 3);
         hold = 1'($urandom);
         gap  = $urandom_range(0, 2);
         if (ns != sel || gap > 0) begin
            data_valid = 1'b0;
            sel = ns;
            repeat (gap + 1) @(negedge clk);
         end
         scr = hold ? $urandom_range(1, sel ? 10 : 40) : 0;
         accept_word(d, m, hold, waits);
         check_frame(model_frame(d, m), scr, 8'($urandom), 1'($urandom));
      end
      data_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
